// File: rtl/cmd_exec_pkg.sv
// Shared definitions for the command executor: opcodes, FSM states, error codes and field layout.
package cmd_exec_pkg;

    localparam int unsigned CmdW   = 32;
    localparam int unsigned OpMsb  = 31;
    localparam int unsigned OpLsb  = 28;
    localparam int unsigned ArgW   = 28;

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpStart = 4'd1;
    localparam logic [3:0] OpSrst  = 4'd2;
    localparam logic [3:0] OpStclr = 4'd3;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrIllegal = 2'd1;
    localparam logic [1:0] ErrCore    = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StStart,
        StRun,
        StSrst,
        StClr
    } state_e;

endpackage

// File: rtl/cmd_timer.sv
// Loadable down-counter with a zero flag; shared by the soft-reset length and the RUN timeout.
module cmd_timer #(
    parameter int unsigned W = 4
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cmd_exec.sv
// Command executor: latches a host command, starts or soft-resets the decoder core, returns cmd_clr.
// Optional RUN timeout is enabled by defining CMD_TIMEOUT_EN.
module cmd_exec
    import cmd_exec_pkg::*;
#(
    parameter int unsigned SRST_CYCLES = 4,
    parameter int unsigned TO_W        = 20
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            cmd_int_req,
    input  logic [CmdW-1:0] cmd_di,
    output logic            cmd_clr,
    output logic            dec_start,
    output logic [ArgW-1:0] dec_arg,
    output logic            dec_soft_rst,
    input  logic            dec_done,
    input  logic            dec_err,
    output logic            sts_busy,
    output logic [1:0]      sts_err,
    output logic            sts_drop
);

    localparam int unsigned SrstW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;
`ifdef CMD_TIMEOUT_EN
    localparam int unsigned CntW = (TO_W > SrstW) ? TO_W : SrstW;
    // Loaded on leaving START so the counter hits zero in the (2^TO_W - 1)th RUN cycle.
    localparam logic [CntW-1:0] ToLoad = CntW'((64'd1 << TO_W) - 64'd2);
`else
    localparam int unsigned CntW = SrstW;
`endif
    localparam logic [CntW-1:0] SrstLoad = CntW'(SRST_CYCLES - 1);

    if (SRST_CYCLES < 1 || TO_W < 1) begin : g_param_check
        $error("cmd_exec: SRST_CYCLES and TO_W must be at least 1");
    end

    state_e          state_q;
    logic [CmdW-1:0] cmd_word_q;
    logic [3:0]      op;
    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_dec;
    logic            tmr_zero;

    assign op = cmd_word_q[OpMsb:OpLsb];

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SrstLoad;
        tmr_dec  = (state_q == StSrst);
        unique case (state_q)
            StDecode: tmr_load = (op == OpSrst);
`ifdef CMD_TIMEOUT_EN
            StStart: begin
                tmr_load = 1'b1;
                tmr_val  = ToLoad;
            end
            StRun: begin
                tmr_dec  = 1'b1;
                tmr_load = !dec_done && tmr_zero;
            end
`endif
            default: ;
        endcase
    end

    cmd_timer #(
        .W (CntW)
    ) u_timer (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cmd_word_q   <= '0;
            dec_arg      <= '0;
            cmd_clr      <= 1'b0;
            dec_start    <= 1'b0;
            dec_soft_rst <= 1'b0;
            sts_err      <= ErrNone;
            sts_drop     <= 1'b0;
        end else begin
            cmd_clr   <= 1'b0;
            dec_start <= 1'b0;
            if (cmd_int_req && (state_q != StIdle)) begin
                sts_drop <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (cmd_int_req) begin
                        cmd_word_q <= cmd_di;
                        state_q    <= StDecode;
                    end
                end
                StDecode: begin
                    case (op)
                        OpNop: begin
                            cmd_clr <= 1'b1;
                            state_q <= StClr;
                        end
                        OpStart: begin
                            dec_arg   <= cmd_word_q[ArgW-1:0];
                            dec_start <= 1'b1;
                            state_q   <= StStart;
                        end
                        OpSrst: begin
                            dec_soft_rst <= 1'b1;
                            state_q      <= StSrst;
                        end
                        OpStclr: begin
                            sts_err  <= ErrNone;
                            // A request landing in this very cycle is still a drop.
                            sts_drop <= cmd_int_req;
                            cmd_clr  <= 1'b1;
                            state_q  <= StClr;
                        end
                        default: begin
                            sts_err <= ErrIllegal;
                            cmd_clr <= 1'b1;
                            state_q <= StClr;
                        end
                    endcase
                end
                StStart: state_q <= StRun;
                StRun: begin
                    if (dec_done) begin
                        if (dec_err) begin
                            sts_err <= ErrCore;
                        end
                        cmd_clr <= 1'b1;
                        state_q <= StClr;
                    end
`ifdef CMD_TIMEOUT_EN
                    else if (tmr_zero) begin
                        sts_err      <= ErrTimeout;
                        dec_soft_rst <= 1'b1;
                        state_q      <= StSrst;
                    end
`endif
                end
                StSrst: begin
                    if (tmr_zero) begin
                        dec_soft_rst <= 1'b0;
                        cmd_clr      <= 1'b1;
                        state_q      <= StClr;
                    end
                end
                StClr: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sts_busy = (state_q != StIdle);

endmodule

// File: tb/tb_cmd_exec.sv
// Directed self-checking bench for cmd_exec (SRST_CYCLES=4, TO_W=4).
module tb_cmd_exec;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_int_req = 1'b0;
    logic [31:0] cmd_di = '0;
    logic        cmd_clr;
    logic        dec_start;
    logic [27:0] dec_arg;
    logic        dec_soft_rst;
    logic        dec_done = 1'b0;
    logic        dec_err = 1'b0;
    logic        sts_busy;
    logic [1:0]  sts_err;
    logic        sts_drop;

    int n_checks = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    cmd_exec #(
        .SRST_CYCLES (4),
        .TO_W        (4)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .cmd_int_req  (cmd_int_req),
        .cmd_di       (cmd_di),
        .cmd_clr      (cmd_clr),
        .dec_start    (dec_start),
        .dec_arg      (dec_arg),
        .dec_soft_rst (dec_soft_rst),
        .dec_done     (dec_done),
        .dec_err      (dec_err),
        .sts_busy     (sts_busy),
        .sts_err      (sts_err),
        .sts_drop     (sts_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the negedge of the DECODE cycle.
    task automatic send(input logic [31:0] word);
        @(negedge sys_clk);
        cmd_di      = word;
        cmd_int_req = 1'b1;
        @(negedge sys_clk);
        cmd_int_req = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_clr"},   32'(cmd_clr), 0);
        check({tag, "_start"}, 32'(dec_start), 0);
        check({tag, "_arg"},   32'(dec_arg), 0);
        check({tag, "_srst"},  32'(dec_soft_rst), 0);
        check({tag, "_busy"},  32'(sts_busy), 0);
        check({tag, "_err"},   32'(sts_err), 0);
        check({tag, "_drop"},  32'(sts_drop), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge sys_clk);
        check_reset_values("rst");
        rst = 1'b1;

        // NOP
        send(32'h0000_0000);
        check("nop_decode_busy", 32'(sts_busy), 1);
        check("nop_decode_clr", 32'(cmd_clr), 0);
        @(negedge sys_clk);
        check("nop_clr", 32'(cmd_clr), 1);
        check("nop_start", 32'(dec_start), 0);
        @(negedge sys_clk);
        check("nop_clr_once", 32'(cmd_clr), 0);
        check("nop_idle", 32'(sts_busy), 0);
        check("nop_err", 32'(sts_err), 0);

        // START, core error, plus a dropped request while running
        send(32'h1000_4000);
        @(negedge sys_clk);
        check("start_pulse", 32'(dec_start), 1);
        check("start_arg", 32'(dec_arg), 32'h000_4000);
        @(negedge sys_clk);
        check("start_once", 32'(dec_start), 0);
        check("run_busy", 32'(sts_busy), 1);
        cmd_di      = 32'h1000_0777;
        cmd_int_req = 1'b1;
        @(negedge sys_clk);
        cmd_int_req = 1'b0;
        check("run_drop", 32'(sts_drop), 1);
        check("run_no_latch", 32'(dec_arg), 32'h000_4000);
`ifdef CMD_TIMEOUT_EN
        repeat (8) @(negedge sys_clk);
`else
        repeat (46) @(negedge sys_clk);
`endif
        check("run_no_clr", 32'(cmd_clr), 0);
        dec_done = 1'b1;
        dec_err  = 1'b1;
        @(negedge sys_clk);
        dec_done = 1'b0;
        dec_err  = 1'b0;
        check("done_clr", 32'(cmd_clr), 1);
        check("done_err", 32'(sts_err), 2);
        @(negedge sys_clk);
        check("done_idle", 32'(sts_busy), 0);
        dec_done = 1'b1;
        @(negedge sys_clk);
        dec_done = 1'b0;
        check("idle_done_ignored", 32'(cmd_clr), 0);

        // SRST length
        send(32'h2000_0000);
        @(negedge sys_clk);
        n = 0;
        while (dec_soft_rst && n < 20) begin
            n++;
            @(negedge sys_clk);
        end
        check("srst_len", 32'(n), 4);
        check("srst_clr", 32'(cmd_clr), 1);

        // Illegal opcode, then back-to-back STCLR in the IDLE cycle after CLR
        send(32'hF000_0000);
        @(negedge sys_clk);
        check("ill_clr", 32'(cmd_clr), 1);
        check("ill_err", 32'(sts_err), 1);
        check("ill_drop_sticky", 32'(sts_drop), 1);
        send(32'h3000_0000);
        @(negedge sys_clk);
        check("stclr_clr", 32'(cmd_clr), 1);
        check("stclr_err", 32'(sts_err), 0);
        check("stclr_drop", 32'(sts_drop), 0);

`ifdef CMD_TIMEOUT_EN
        // Timeout: 15 RUN cycles, then soft reset and CLR
        send(32'h1000_0010);
        @(negedge sys_clk);
        check("to_start", 32'(dec_start), 1);
        @(negedge sys_clk);
        n = 0;
        while (!dec_soft_rst && n < 40) begin
            n++;
            @(negedge sys_clk);
        end
        check("to_run_len", 32'(n), 15);
        check("to_err", 32'(sts_err), 3);
        n = 0;
        while (dec_soft_rst && n < 20) begin
            n++;
            @(negedge sys_clk);
        end
        check("to_srst_len", 32'(n), 4);
        check("to_clr", 32'(cmd_clr), 1);
        send(32'h3000_0000);
        repeat (2) @(negedge sys_clk);
`endif

        // Reset while running, then a normal request
        send(32'h1000_0123);
        @(negedge sys_clk);
        check("rr_start", 32'(dec_start), 1);
        @(negedge sys_clk);
        rst = 1'b0;
        #1;
        check_reset_values("rr");
        @(negedge sys_clk);
        check("rr_no_clr", 32'(cmd_clr), 0);
        rst = 1'b1;
        send(32'h0000_0000);
        @(negedge sys_clk);
        check("rr_next_clr", 32'(cmd_clr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
